chrono_controller: RTL and testbench

- Control FSM for the 4-digit chronometer counter (ss.s / mm-style BCD chain).
- Takes two raw push-buttons (start/stop, lap/reset), then synchronises, debounces and edge-detects them.
- Produces a prescaled count-enable tick, a synchronous clear and a lap display-freeze for the counter/display path.
- Sits between the board buttons and the digit counter chain; the counter advances only on cycles where cnt_en is high.

---
 rtl/chrono_controller.sv | 127 ++++++++++++
 tb/tb_chrono_controller.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/chrono_controller.sv
// Chronometer control FSM: synchronises and debounces the start/stop and lap/reset buttons,
// and drives the count-enable tick, the counter clear and the lap display freeze.
module chrono_controller #(
  parameter int unsigned TICK_DIV   = 1000000,
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       btn_ss,
  input  logic       btn_lr,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       freeze,
  output logic [1:0] state
);

  localparam int unsigned DW = $clog2(DEB_CYCLES) + 1;
  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DebMax = DW'(DEB_CYCLES - 1);
  localparam logic [PW-1:0] PscMax = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StLap  = 2'd2,
    StStop = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            en_q, en_d, clr_q, clr_d, frz_q, frz_d;

  // Bit 0 is start/stop, bit 1 is lap/reset.
  logic [1:0]      raw, sync1_q, sync2_q, deb_q, deb_prev_q, press_q;
  logic [DW-1:0]   dcnt_q [2];
  logic            ss_p, lr_p, run_q, run_d;

  assign raw  = {btn_lr, btn_ss};
  assign ss_p = press_q[0];
  assign lr_p = press_q[1];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      press_q    <= '0;
      dcnt_q[0]  <= '0;
      dcnt_q[1]  <= '0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      // Press pulse is registered so no path exists from a button to the FSM in one cycle.
      press_q    <= deb_q & ~deb_prev_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          dcnt_q[i] <= '0;
        end else if (dcnt_q[i] == DebMax) begin
          deb_q[i]  <= ~deb_q[i];
          dcnt_q[i] <= '0;
        end else begin
          dcnt_q[i] <= dcnt_q[i] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      presc_q <= '0;
      en_q    <= 1'b0;
      clr_q   <= 1'b0;
      frz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      en_q    <= en_d;
      clr_q   <= clr_d;
      frz_q   <= frz_d;
    end
  end

  // Start/stop wins over lap/reset when both pulse together.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (ss_p) state_d = StRun;
      StRun: begin
        if (ss_p)      state_d = StStop;
        else if (lr_p) state_d = StLap;
      end
      StLap: begin
        if (ss_p)      state_d = StStop;
        else if (lr_p) state_d = StRun;
      end
      StStop: begin
        if (ss_p)      state_d = StRun;
        else if (lr_p) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    run_q   = (state_q == StRun) || (state_q == StLap);
    run_d   = (state_d == StRun) || (state_d == StLap);
    clr_d   = lr_p && !ss_p && ((state_q == StIdle) || (state_q == StStop));
    // A tick due on the edge that leaves RUN/LAP is suppressed and the phase is kept.
    en_d    = run_q && run_d && (presc_q == PscMax);
    frz_d   = (state_d == StLap);
    presc_d = presc_q;
    if (state_d == StIdle) begin
      presc_d = '0;
    end else if (run_q && run_d) begin
      presc_d = (presc_q == PscMax) ? '0 : presc_q + PW'(1);
    end
  end

  assign state   = state_q;
  assign cnt_en  = en_q;
  assign cnt_clr = clr_q;
  assign freeze  = frz_q;

endmodule

// File: tb/tb_chrono_controller.sv
// Bench for chrono_controller: directed scenarios plus random button activity, every cycle
// compared against a behavioural model of the button path, state table and tick cadence.
module tb_chrono_controller;

  localparam int TD = 4;
  localparam int DB = 3;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       btn_ss = 1'b0;
  logic       btn_lr = 1'b0;
  logic       cnt_en, cnt_clr, freeze;
  logic [1:0] state;

  chrono_controller #(.TICK_DIV(TD), .DEB_CYCLES(DB)) dut (
    .CLK(CLK), .RST(RST), .btn_ss(btn_ss), .btn_lr(btn_lr),
    .cnt_en(cnt_en), .cnt_clr(cnt_clr), .freeze(freeze), .state(state)
  );

  always #5 CLK = ~CLK;

  int nchk  = 0;
  int nfail = 0;

  // Model: state as 0..3, prescaler phase, button sample pipeline and stable-run counts.
  int m_state, m_presc;
  bit m_en, m_clr, m_frz;
  bit m_s1 [2], m_s2 [2], m_lvl [2], m_rose [2], m_p [2];
  int m_run [2];

  function automatic int next_state(int s, bit ss, bit lr);
    if (ss) return (s == 1 || s == 2) ? 3 : 1;
    if (lr) begin
      case (s)
        0: return 0;
        1: return 2;
        2: return 1;
        default: return 0;
      endcase
    end
    return s;
  endfunction

  task automatic model_reset();
    m_state = 0; m_presc = 0; m_en = 0; m_clr = 0; m_frz = 0;
    for (int i = 0; i < 2; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_rose[i] = 0; m_p[i] = 0; m_run[i] = 0;
    end
  endtask

  task automatic model_step();
    bit raw [2];
    int ns;
    bit ro, rn;
    raw[0] = btn_ss;
    raw[1] = btn_lr;
    if (!RST) begin
      model_reset();
      return;
    end
    ns    = next_state(m_state, m_p[0], m_p[1]);
    ro    = (m_state == 1 || m_state == 2);
    rn    = (ns == 1 || ns == 2);
    m_clr = m_p[1] && !m_p[0] && (m_state == 0 || m_state == 3);
    m_en  = ro && rn && (m_presc == TD - 1);
    if (ns == 0)      m_presc = 0;
    else if (ro && rn) m_presc = (m_presc + 1) % TD;
    m_frz   = (ns == 2);
    m_state = ns;
    for (int i = 0; i < 2; i++) begin
      m_p[i]    = m_rose[i];
      m_rose[i] = 0;
      if (m_s2[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_lvl[i]  = !m_lvl[i];
          m_run[i]  = 0;
          m_rose[i] = m_lvl[i];
        end
      end else begin
        m_run[i] = 0;
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = raw[i];
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    nchk++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("state", {2'b00, state}, 4'(m_state));
    chk("cnt_en", {3'b000, cnt_en}, {3'b000, m_en});
    chk("cnt_clr", {3'b000, cnt_clr}, {3'b000, m_clr});
    chk("freeze", {3'b000, freeze}, {3'b000, m_frz});
    chk("en_clr_excl", {3'b000, cnt_en & cnt_clr}, 4'd0);
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      model_step();
      @(negedge CLK);
      check_all();
    end
  endtask

  // Hold one or both buttons for `hold` cycles, then let them settle low.
  task automatic press(input bit ss, input bit lr, input int hold);
    btn_ss = ss;
    btn_lr = lr;
    cyc(hold);
    btn_ss = 0;
    btn_lr = 0;
    cyc(8);
  endtask

  // Counts edges from the current negedge until state reaches `target`, bounded.
  task automatic latency(input string tag, input int target, input int expect_edges);
    int n;
    n = -1;
    for (int i = 0; i < 16; i++) begin
      cyc(1);
      if (n < 0 && state == 2'(target)) n = i;
    end
    chk(tag, 4'(n), 4'(expect_edges));
  endtask

  int dur_ss, dur_lr;

  initial begin
    model_reset();
    #1 RST = 1'b0;
    #1 check_all();
    cyc(3);
    RST = 1'b1;
    cyc(2);

    // Short glitch in IDLE is filtered out.
    btn_ss = 1;
    cyc(2);
    btn_ss = 0;
    cyc(10);
    chk("glitch_idle", {2'b00, state}, 4'd0);

    // Start: RUN six edges after the first high sample, then tick cadence.
    btn_ss = 1;
    latency("start_latency", 1, DB + 3);
    btn_ss = 0;
    cyc(12);

    // Lap and back.
    press(0, 1, 5);
    chk("lap_state", {2'b00, state}, 4'd2);
    chk("lap_freeze", {3'b000, freeze}, 4'd1);
    cyc(9);
    press(0, 1, 5);
    chk("unlap_state", {2'b00, state}, 4'd1);

    // Stop, resume, stop, reset.
    cyc(1);
    press(1, 0, 5);
    chk("stop_state", {2'b00, state}, 4'd3);
    cyc(5);
    press(1, 0, 5);
    cyc(3);
    press(1, 0, 5);
    press(0, 1, 5);
    chk("reset_state", {2'b00, state}, 4'd0);

    // Simultaneous press in RUN: start/stop wins.
    press(1, 0, 5);
    press(1, 1, 5);
    chk("both_state", {2'b00, state}, 4'd3);
    chk("both_freeze", {3'b000, freeze}, 4'd0);

    // Async reset in LAP mid-debounce, button held through release.
    press(1, 0, 5);
    press(0, 1, 5);
    chk("pre_rst_lap", {2'b00, state}, 4'd2);
    btn_ss = 1;
    cyc(2);
    #2 RST = 1'b0;
    #1 model_reset();
    check_all();
    cyc(2);
    RST = 1'b1;
    latency("rst_release_latency", 1, DB + 3);
    btn_ss = 0;
    cyc(6);

    // Random button activity with random hold lengths (glitches and overlaps included).
    dur_ss = 0;
    dur_lr = 0;
    for (int i = 0; i < 1500; i++) begin
      if (dur_ss == 0) begin
        btn_ss = 1'($urandom_range(0, 1));
        dur_ss = $urandom_range(1, 9);
      end
      if (dur_lr == 0) begin
        btn_lr = 1'($urandom_range(0, 1));
        dur_lr = $urandom_range(1, 9);
      end
      dur_ss--;
      dur_lr--;
      cyc(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
